// File: rtl/ps2_kbd_pkg.sv
// Shared constants, event type and scan-code helpers for the PS/2 keyboard receiver.
// The ASCII helper is only referenced when PS2_ASCII_XLATE_EN is defined.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT  = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK  = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT      = 8'h12;
    localparam logic [7:0] PS2_RSHIFT      = 8'h59;

    // Keyboard status/protocol bytes that never represent a key.
    localparam logic [7:0] PS2_DROP_ERR0   = 8'h00;
    localparam logic [7:0] PS2_DROP_BAT    = 8'hAA;
    localparam logic [7:0] PS2_DROP_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_DROP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_DROP_RESEND = 8'hFE;
    localparam logic [7:0] PS2_DROP_ERR1   = 8'hFF;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic       shift;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic ps2_is_drop(input logic [7:0] code);
        return code inside {PS2_DROP_ERR0, PS2_DROP_BAT, PS2_DROP_ECHO,
                            PS2_DROP_ACK, PS2_DROP_RESEND, PS2_DROP_ERR1};
    endfunction

    function automatic logic [6:0] ps2_ascii(input logic [7:0] code, input logic shift);
        logic [6:0] ch;
        ch = 7'h00;
        case (code)
            8'h1C: ch = 7'h61; 8'h32: ch = 7'h62; 8'h21: ch = 7'h63; 8'h23: ch = 7'h64;
            8'h24: ch = 7'h65; 8'h2B: ch = 7'h66; 8'h34: ch = 7'h67; 8'h33: ch = 7'h68;
            8'h43: ch = 7'h69; 8'h3B: ch = 7'h6A; 8'h42: ch = 7'h6B; 8'h4B: ch = 7'h6C;
            8'h3A: ch = 7'h6D; 8'h31: ch = 7'h6E; 8'h44: ch = 7'h6F; 8'h4D: ch = 7'h70;
            8'h15: ch = 7'h71; 8'h2D: ch = 7'h72; 8'h1B: ch = 7'h73; 8'h2C: ch = 7'h74;
            8'h3C: ch = 7'h75; 8'h2A: ch = 7'h76; 8'h1D: ch = 7'h77; 8'h22: ch = 7'h78;
            8'h35: ch = 7'h79; 8'h1A: ch = 7'h7A;
            8'h45: ch = 7'h30; 8'h16: ch = 7'h31; 8'h1E: ch = 7'h32; 8'h26: ch = 7'h33;
            8'h25: ch = 7'h34; 8'h2E: ch = 7'h35; 8'h36: ch = 7'h36; 8'h3D: ch = 7'h37;
            8'h3E: ch = 7'h38; 8'h46: ch = 7'h39;
            8'h29: ch = 7'h20;
            default: ch = 7'h00;
        endcase
        if (shift && ch >= 7'h61 && ch <= 7'h7A) begin
            ch = ch - 7'h20;
        end
        return ch;
    endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_frame_rx.sv
// PS/2 line synchroniser, keyboard-clock glitch filter and 11-bit frame deserialiser
// with odd-parity/stop checking and an inactivity timeout.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_strobe_o,
    output logic       err_strobe_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          strobe_q, strobe_d;
    logic          err_q, err_d;
    logic          fall;
    logic          dat;

    assign dat = dat_sync_q[1];

    // NOTE: every variable gets a default at the top of a combinational block so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_clk_q & ~filt_clk_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        byte_d    = byte_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {dat, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if ((^{shreg_q, parity_q}) && dat) begin
                        byte_d   = shreg_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            byte_q     <= 8'h00;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    assign byte_o        = byte_q;
    assign byte_strobe_o = strobe_q;
    assign err_strobe_o  = err_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard front end: prefix decode, shift tracking and a show-ahead event FIFO.
// Define PS2_ASCII_XLATE_EN to store shift state per event and drive key_ascii.
module ps2_keyboard_receiver
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_extended,
    output logic [6:0] key_ascii,
    output logic       shift_active,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PS2_ASCII_XLATE_EN
    localparam int ENTRY_W = $bits(ps2_event_t);
`else
    localparam int ENTRY_W = $bits(ps2_event_t) - 1;
`endif

    logic [7:0] rx_byte;
    logic       rx_strobe;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk_i     (PS2_KBCLK),
        .ps2_dat_i     (PS2_KBDAT),
        .byte_o        (rx_byte),
        .byte_strobe_o (rx_strobe),
        .err_strobe_o  (frame_err)
    );

    logic ext_pend_q, ext_pend_d;
    logic brk_pend_q, brk_pend_d;
    logic lshift_q, lshift_d;
    logic rshift_q, rshift_d;
    logic push;

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        push       = 1'b0;
        if (rx_strobe) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!ps2_is_drop(rx_byte)) begin
                    push = 1'b1;
                    // Extended 12/59 are distinct keys (e.g. print screen), not shift.
                    if (!ext_pend_q && rx_byte == PS2_LSHIFT) lshift_d = !brk_pend_q;
                    if (!ext_pend_q && rx_byte == PS2_RSHIFT) rshift_d = !brk_pend_q;
                end
            end
        end
    end

    assign shift_active = lshift_q | rshift_q;

    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic               empty, full, pop, push_ok;

`ifdef PS2_ASCII_XLATE_EN
    ps2_event_t wr_evt;
    assign wr_evt  = '{extended: ext_pend_q, brk: brk_pend_q, shift: shift_active, code: rx_byte};
    assign wr_data = wr_evt;
`else
    assign wr_data = {ext_pend_q, brk_pend_q, rx_byte};
`endif

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && key_ready;
    assign push_ok = push && (!full || pop);

    // NOTE: the storage array has no reset; its contents are only observed
    // through pointers that are reset, and outputs are gated by key_valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow   <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            wr_ptr_q   <= wr_ptr_q + {{AW{1'b0}}, push_ok};
            rd_ptr_q   <= rd_ptr_q + {{AW{1'b0}}, pop};
            overflow   <= push && full && !pop;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign key_valid    = !empty;
    assign key_code     = key_valid ? head[7:0] : 8'h00;
    assign key_break    = key_valid & head[ENTRY_W-2];
    assign key_extended = key_valid & head[ENTRY_W-1];

`ifdef PS2_ASCII_XLATE_EN
    assign key_ascii = (key_valid && !key_break && !key_extended) ? ps2_ascii(head[7:0], head[8]) : 7'h00;
`else
    assign key_ascii = 7'h00;
`endif

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed self-checking bench for ps2_keyboard_receiver; expected ASCII values
// follow PS2_ASCII_XLATE_EN when it is defined for the build.
module tb_ps2_keyboard_receiver;

    localparam int FIFO_DEPTH     = 8;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 100;

    logic       clk = 1'b0;
    logic       reset, kbclk, kbdat, key_ready;
    logic       key_valid, key_break, key_extended, shift_active, frame_err, overflow;
    logic [7:0] key_code;
    logic [6:0] key_ascii;

    int n_assert = 0;
    int n_fail   = 0;

    logic kv_at6, kv_at7, err_at6, err_at7, sh_at6, sh_at7, ov_at7;

    always #5 clk = ~clk;

    ps2_keyboard_receiver #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PS2_KBCLK    (kbclk),
        .PS2_KBDAT    (kbdat),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_extended (key_extended),
        .key_ascii    (key_ascii),
        .shift_active (shift_active),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_ascii(input logic [6:0] ch);
`ifdef PS2_ASCII_XLATE_EN
        return ch;
`else
        return 7'h00;
`endif
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        kbdat = b;
        wait_neg(4);
        kbclk = 1'b0;
        wait_neg(8);
        kbclk = 1'b1;
        wait_neg(4);
    endtask

    // Stop bit: its filtered fall lands 6 cycles after the line drops, so
    // snapshots at +6/+7 observe cycles E+1 and E+2.
    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        kbdat = 1'b1;
        wait_neg(4);
        kbclk = 1'b0;
        wait_neg(6);
        kv_at6 = key_valid; err_at6 = frame_err; sh_at6 = shift_active;
        wait_neg(1);
        kv_at7 = key_valid; err_at7 = frame_err; sh_at7 = shift_active; ov_at7 = overflow;
        wait_neg(1);
        kbclk = 1'b1;
        wait_neg(4);
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code, input logic brk,
                                input logic ext, input logic [6:0] ascii);
        check({tag, "_valid"}, key_valid, 1'b1);
        check({tag, "_code"}, key_code, code);
        check({tag, "_break"}, key_break, brk);
        check({tag, "_ext"}, key_extended, ext);
        check({tag, "_ascii"}, key_ascii, ascii);
        key_ready = 1'b1;
        wait_neg(1);
        key_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ovf_codes [9];
        logic       seen;
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        reset = 1'b1; kbclk = 1'b1; kbdat = 1'b1; key_ready = 1'b0;
        wait_neg(4);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 8'h00);
        check("rst_ascii", key_ascii, 7'h00);
        check("rst_shift", shift_active, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        wait_neg(2);

        // Single make code and its latency.
        send_frame(8'h1C, 1'b0);
        check("lat_e1_valid", kv_at6, 1'b0);
        check("lat_e2_valid", kv_at7, 1'b1);
        check("good_no_err", err_at6, 1'b0);
        expect_event("ev1c", 8'h1C, 1'b0, 1'b0, exp_ascii(7'h61));
        check("pop_empty", key_valid, 1'b0);

        // Shift make/break around a letter.
        send_frame(8'h12, 1'b0);
        check("shift_e1", sh_at6, 1'b0);
        check("shift_e2", sh_at7, 1'b1);
        send_frame(8'h1C, 1'b0);
        check("shift_held", shift_active, 1'b1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        check("shift_rel", sh_at7, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        expect_event("s_mk12", 8'h12, 1'b0, 1'b0, 7'h00);
        expect_event("s_mk1c", 8'h1C, 1'b0, 1'b0, exp_ascii(7'h41));
        expect_event("s_br12", 8'h12, 1'b1, 1'b0, 7'h00);
        expect_event("s_br1c", 8'h1C, 1'b1, 1'b0, 7'h00);
        check("s_four_only", key_valid, 1'b0);

        // Extended break sequence collapses to one event.
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        check("prefix_no_event", key_valid, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_event("ext_brk75", 8'h75, 1'b1, 1'b1, 7'h00);
        check("ext_one_only", key_valid, 1'b0);
        send_frame(8'h1C, 1'b0);
        expect_event("flags_clear", 8'h1C, 1'b0, 1'b0, exp_ascii(7'h61));

        // Parity error then recovery.
        send_frame(8'h1C, 1'b1);
        check("par_err_pulse", err_at6, 1'b1);
        check("par_err_end", err_at7, 1'b0);
        check("par_no_push", key_valid, 1'b0);
        send_frame(8'h29, 1'b0);
        expect_event("after_par", 8'h29, 1'b0, 1'b0, exp_ascii(7'h20));

        // Abandoned frame: start bit plus four data bits, then silence.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        kbdat = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES + 50 && !seen; i++) begin
            wait_neg(1);
            if (frame_err) seen = 1'b1;
        end
        check("timeout_err", seen, 1'b1);
        wait_neg(1);
        check("timeout_pulse", frame_err, 1'b0);
        check("timeout_no_push", key_valid, 1'b0);
        send_frame(8'h45, 1'b0);
        expect_event("after_to", 8'h45, 1'b0, 1'b0, exp_ascii(7'h30));

        // Overflow on the ninth event, then back-to-back drain.
        for (int i = 0; i < 9; i++) begin
            send_frame(ovf_codes[i], 1'b0);
            check($sformatf("ovf_%0d", i), ov_at7, (i == 8));
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), key_valid, 1'b1);
            check($sformatf("drain_code_%0d", i), key_code, ovf_codes[i]);
            key_ready = 1'b1;
            wait_neg(1);
        end
        key_ready = 1'b0;
        check("drain_empty", key_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_receiver.md
# ps2_keyboard_receiver

System-clocked, parametrised PS/2 keyboard front end. It synchronises and filters the raw keyboard clock and data lines and deserialises frames with start, parity and stop checking. It resolves E0 (extended) and F0 (break) prefixes into single key events, tracks shift state, and buffers events in a FIFO behind a valid/ready handshake. It replaces keyboard-clock-domain capture in the text-entry path; downstream editor logic pops events at its own pace.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2
- FILTER_LEN, 4: consecutive equal samples required to accept a new PS2_KBCLK level
- TIMEOUT_CYCLES, 50000: clk cycles without a keyboard clock fall before a partial frame is abandoned
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- PS2_KBCLK  in  1  raw keyboard clock, asynchronous
- PS2_KBDAT  in  1  raw keyboard data, asynchronous
- key_valid  out  1  FIFO non-empty; head event presented
- key_ready  in  1  consumer accepts head event
- key_code  out  8  head scan code, prefixes removed
- key_break  out  1  head event is a release
- key_extended  out  1  head event was E0-prefixed
- key_ascii  out  7  ASCII of head event (see Configuration)
- shift_active  out  1  left or right shift currently held
- frame_err  out  1  one-cycle pulse: bad parity, bad stop, or timeout
- overflow  out  1  one-cycle pulse: event dropped, FIFO full

## Operation
- Both inputs pass through 2-flop synchronisers. Filtered clock level changes only after FILTER_LEN identical consecutive samples. A filtered 1→0 transition is a "fall"; data is sampled in that cycle.
- Frame FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - In IDLE, fall with data=0 → DATA; fall with data=1 is ignored.
  - At STOP: accept iff parity is odd over 8 data bits plus parity bit, and stop=1. Accept → byte strobe. Otherwise → frame_err; byte discarded.
  - In any non-IDLE state, TIMEOUT_CYCLES with no fall → IDLE plus frame_err.
- Decode on byte strobe:
  - E0 sets ext_pend. F0 sets brk_pend.
  - 00, AA, EE, FA, FE, FF are dropped and clear both flags.
  - Any other byte emits an event {ext_pend, brk_pend, byte} and clears both flags.
- Shift tracking: non-extended 12 (left) and 59 (right) each set a held bit on make and clear it on break. shift_active is the OR of the two. Shift events are still pushed to the FIFO.
- FIFO:
  - Show-ahead: head fields are registered and valid whenever key_valid=1.
  - Pop on key_valid && key_ready.
  - Push while full without a same-cycle pop → event dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle while full → both succeed; no overflow.
  - Push and pop while empty → event written; key_valid rises next cycle.
- Reset values:
  - All outputs 0.
  - Filtered clock and data = 1; FSM IDLE; prefix flags, shift bits and FIFO pointers cleared.
  - Reset mid-frame abandons the frame silently (no frame_err).

## Timing
- Fall detected in cycle E (stop bit) → byte strobe in E+1 → FIFO write at end of E+1 → key_valid=1 and fields valid in E+2.
- frame_err asserts in E+1 for parity/stop errors. Timeout errors assert in the cycle the counter reaches TIMEOUT_CYCLES.
- shift_active updates in E+2, together with key_valid for that event.
- Pop: the next head appears in the cycle after the handshake. Back-to-back pops sustain one event per cycle.
- Counters are sized by $clog2 of each parameter. The timeout counter saturates and restarts on every fall.

## Configuration
- PS2_ASCII_XLATE_EN defined:
  - FIFO entry widens by one bit to store shift_active at event time.
  - key_ascii maps non-extended make codes: A–Z → 'a'–'z', or 'A'–'Z' when the stored shift is 1; digits 0–9 → '0'–'9'; 29 → space (0x20).
  - Break, extended and unmapped codes → 0x00.
- Not defined: key_ascii is tied to 0; no shift bit is stored.

## Structure
- Package ps2_kbd_pkg:
  - Constants: PS2_PREFIX_EXT=E0, PS2_PREFIX_BRK=F0, PS2_LSHIFT=12, PS2_RSHIFT=59, and the drop-list codes.
  - Event struct type {extended, brk, shift, code}.
  - ASCII lookup function.
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout. Outputs byte, byte strobe and error strobe.
- Decode, shift tracking and FIFO live in the top level.

## Test plan
- Frame 1C (parity 0) → key_valid in E+2; code 1C, break 0, extended 0; ASCII 0x61 with macro, 0x00 without.
- Frames 12, 1C, F0 12, F0 1C → shift_active 1 then 0; the second event's key_ascii = 0x41; four events total.
- Frames E0, F0, 75 → exactly one event: code 75, break 1, extended 1; prefix flags clear afterwards.
- Frame 1C with parity bit 1 → frame_err pulse, no FIFO write; the following good frame 29 decodes normally.
- Stop clocking after 4 data bits for TIMEOUT_CYCLES → frame_err, FSM IDLE; next frame 45 yields code 45.
- key_ready=0, send FIFO_DEPTH+1 makes 16,1E,26,25,2E,36,3D,3E,46 → overflow pulse on the ninth; drain yields the first eight in order.
